// File: rtl/postoffice_multichannel_if.sv
// Handshake bundle between the send queues, post office, loopback interceptor,
// commit safety unit and writeback arbiter.
interface postoffice_multichannel_if #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned MSG_W        = 32,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned GL_W         = 6,
    parameter int unsigned VAL_W        = 32
);
    logic [NUM_CHANNELS-1:0]             send_queue_postoffice_valid;
    logic [NUM_CHANNELS-1:0]             postoffice_send_queue_ready;
    logic [NUM_CHANNELS-1:0][ADDR_W-1:0] send_queue_postoffice_address;
    logic [NUM_CHANNELS-1:0][MSG_W-1:0]  send_queue_postoffice_message;
    logic [NUM_CHANNELS-1:0][REG_W-1:0]  send_queue_postoffice_register;
    logic [NUM_CHANNELS-1:0][GL_W-1:0]   send_queue_postoffice_gl_index;

    logic                                postoffice_writeback_arbiter_valid;
    logic                                writeback_arbiter_postoffice_acknowledge;
    logic [REG_W-1:0]                    postoffice_writeback_arbiter_register;
    logic [VAL_W-1:0]                    postoffice_writeback_arbiter_value;
    logic [GL_W-1:0]                     postoffice_writeback_arbiter_gl_index;

    logic                                postoffice_loopback_valid;
    logic                                loopback_postoffice_ready;
    logic [ADDR_W-1:0]                   postoffice_loopback_address;
    logic [MSG_W-1:0]                    postoffice_loopback_message;

    logic [GL_W-1:0]                     postoffice_csu_request;
    logic                                csu_postoffice_grant;

    modport master (
        output send_queue_postoffice_valid, send_queue_postoffice_address,
               send_queue_postoffice_message, send_queue_postoffice_register,
               send_queue_postoffice_gl_index, writeback_arbiter_postoffice_acknowledge,
               loopback_postoffice_ready, csu_postoffice_grant,
        input  postoffice_send_queue_ready, postoffice_writeback_arbiter_valid,
               postoffice_writeback_arbiter_register, postoffice_writeback_arbiter_value,
               postoffice_writeback_arbiter_gl_index, postoffice_loopback_valid,
               postoffice_loopback_address, postoffice_loopback_message, postoffice_csu_request
    );

    modport slave (
        input  send_queue_postoffice_valid, send_queue_postoffice_address,
               send_queue_postoffice_message, send_queue_postoffice_register,
               send_queue_postoffice_gl_index, writeback_arbiter_postoffice_acknowledge,
               loopback_postoffice_ready, csu_postoffice_grant,
        output postoffice_send_queue_ready, postoffice_writeback_arbiter_valid,
               postoffice_writeback_arbiter_register, postoffice_writeback_arbiter_value,
               postoffice_writeback_arbiter_gl_index, postoffice_loopback_valid,
               postoffice_loopback_address, postoffice_loopback_message, postoffice_csu_request
    );
endinterface

// File: rtl/postoffice_multichannel.sv
// Multichannel post office: round-robin send arbitration, hart-ID window check,
// loopback issue under CSU grant and a writeback FIFO decoupling acknowledge latency.
module postoffice_multichannel #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned WB_DEPTH     = 4,
    parameter int unsigned MIN_HARTID   = 0,
    parameter int unsigned MAX_HARTID   = 64,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned MSG_W        = 32,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned GL_W         = 6,
    parameter int unsigned VAL_W        = 32,
    localparam int unsigned CNT_W       = $clog2(WB_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    postoffice_multichannel_if.slave po,
    output logic [CNT_W-1:0]     postoffice_wb_count
);
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    typedef struct packed {
        logic [REG_W-1:0] dst_reg;
        logic             value;
        logic [GL_W-1:0]  gl_index;
    } wb_entry_t;

    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d, grant_idx, cand;
    logic             grant_valid, dest_ok, wb_alloc_ok, accept, pop;
    logic [31:0]      addr_ext;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    wb_entry_t        mem_q [WB_DEPTH];
    wb_entry_t        head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == WB_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CHANNELS);
            if (!grant_valid && po.send_queue_postoffice_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Offset compare: addresses below MIN_HARTID wrap to large values and fail.
    assign addr_ext    = 32'(po.send_queue_postoffice_address[grant_idx]);
    assign dest_ok     = (addr_ext - 32'(MIN_HARTID)) <= 32'(MAX_HARTID - MIN_HARTID);
    assign pop         = po.writeback_arbiter_postoffice_acknowledge && (count_q != '0);
    assign wb_alloc_ok = (32'(count_q) < WB_DEPTH) || pop;
    assign accept      = !rst && grant_valid && wb_alloc_ok &&
                         (!dest_ok || (po.loopback_postoffice_ready && po.csu_postoffice_grant));

    always_comb begin
        po.postoffice_send_queue_ready = '0;
        if (accept) po.postoffice_send_queue_ready[grant_idx] = 1'b1;
    end

    assign po.postoffice_loopback_valid   = accept && dest_ok;
    assign po.postoffice_loopback_address = po.send_queue_postoffice_address[grant_idx];
    assign po.postoffice_loopback_message = po.send_queue_postoffice_message[grant_idx];
    assign po.postoffice_csu_request      = po.send_queue_postoffice_gl_index[grant_idx];

    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            count_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            rr_ptr_d = '0;
        end else begin
            if (accept) tail_d = ptr_inc(tail_q);
            if (pop)    head_d = ptr_inc(head_q);
            if (accept && !pop)      count_d = count_q + CNT_W'(1);
            else if (!accept && pop) count_d = count_q - CNT_W'(1);
            if (accept) begin
                rr_ptr_d = (32'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Entry storage needs no reset; occupancy alone qualifies the head.
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            mem_q[tail_q] <= '{dst_reg:  po.send_queue_postoffice_register[grant_idx],
                               value:    dest_ok,
                               gl_index: po.send_queue_postoffice_gl_index[grant_idx]};
        end
    end

    assign head_entry                               = mem_q[head_q];
    assign po.postoffice_writeback_arbiter_valid    = !rst && (count_q != '0);
    assign po.postoffice_writeback_arbiter_register = head_entry.dst_reg;
    assign po.postoffice_writeback_arbiter_value    = VAL_W'(head_entry.value);
    assign po.postoffice_writeback_arbiter_gl_index = head_entry.gl_index;
    assign postoffice_wb_count                      = count_q;
endmodule

// File: tb/tb_postoffice_multichannel.sv
// Randomised scoreboard bench for postoffice_multichannel against a queue-based
// reference model of arbitration, destination window and writeback FIFO.
module tb_postoffice_multichannel;
    localparam int unsigned NC   = 2;
    localparam int unsigned WBD  = 4;
    localparam int unsigned MINH = 0;
    localparam int unsigned MAXH = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] wb_count;

    postoffice_multichannel_if #(.NUM_CHANNELS(NC)) po ();

    postoffice_multichannel #(
        .NUM_CHANNELS(NC),
        .WB_DEPTH    (WBD),
        .MIN_HARTID  (MINH),
        .MAX_HARTID  (MAXH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .po                 (po),
        .postoffice_wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] dst_reg;
        logic       value;
        logic [5:0] gl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rr     = 0;

    int phases[7][6] = '{
        '{100, 100, 100, 100,   0,  40},
        '{100, 100, 100,   0,   0,  20},
        '{100, 100, 100,   0,   0,   3},
        '{100, 100, 100,   0, 100,   1},
        '{ 70,  60,  60,  50,   3, 800},
        '{ 80,  20,  50,  30,   0, 300},
        '{ 60,  80,  80,  70,  10, 300}
    };

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit in_window(input int unsigned a);
        return longint'(a) >= longint'(MINH) && longint'(a) <= longint'(MAXH);
    endfunction

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(3))
            0:       return 8'($urandom_range(7));
            1:       return 8'($urandom_range(67, 62));
            2:       return 8'($urandom());
            default: return ($urandom_range(1) != 0) ? 8'd64 : 8'd65;
        endcase
    endfunction

    task automatic idle_inputs();
        po.send_queue_postoffice_valid              = '0;
        po.send_queue_postoffice_address            = '0;
        po.send_queue_postoffice_message            = '0;
        po.send_queue_postoffice_register           = '0;
        po.send_queue_postoffice_gl_index           = '0;
        po.writeback_arbiter_postoffice_acknowledge = 1'b0;
        po.loopback_postoffice_ready                = 1'b0;
        po.csu_postoffice_grant                     = 1'b0;
        flush                                       = 1'b0;
    endtask

    // One clock of random stimulus; the model predicts the combinational response
    // and books the expected writeback entry at the clock edge.
    task automatic cycle(input int pv, input int plr, input int pcsu, input int pack,
                         input int pfl);
        int          grant;
        bit          dok, acc;
        logic [NC-1:0] exp_ready;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            po.send_queue_postoffice_valid[c]    = ($urandom_range(99) < pv);
            po.send_queue_postoffice_address[c]  = rand_addr();
            po.send_queue_postoffice_message[c]  = $urandom();
            po.send_queue_postoffice_register[c] = 5'($urandom());
            po.send_queue_postoffice_gl_index[c] = 6'($urandom());
        end
        po.loopback_postoffice_ready                = ($urandom_range(99) < plr);
        po.csu_postoffice_grant                     = ($urandom_range(99) < pcsu);
        po.writeback_arbiter_postoffice_acknowledge = ($urandom_range(99) < pack);
        flush                                       = ($urandom_range(99) < pfl);
        #1;
        grant = -1;
        for (int k = 0; k < NC; k++) begin
            int c = (rr + k) % NC;
            if (grant < 0 && po.send_queue_postoffice_valid[c]) grant = c;
        end
        dok = (grant >= 0) && in_window(int'(po.send_queue_postoffice_address[grant]));
        acc = (grant >= 0) &&
              (!dok || (po.loopback_postoffice_ready && po.csu_postoffice_grant)) &&
              (exp_q.size() < WBD ||
               (po.writeback_arbiter_postoffice_acknowledge && exp_q.size() != 0));
        exp_ready = '0;
        if (acc) exp_ready[grant] = 1'b1;
        check("ready", 64'(po.postoffice_send_queue_ready), 64'(exp_ready));
        check("loopback_valid", 64'(po.postoffice_loopback_valid), 64'(acc && dok));
        if (acc && dok) begin
            check("loopback_message", 64'(po.postoffice_loopback_message),
                  64'(po.send_queue_postoffice_message[grant]));
            check("loopback_address", 64'(po.postoffice_loopback_address),
                  64'(po.send_queue_postoffice_address[grant]));
        end
        if (grant >= 0 && dok) begin
            check("csu_request", 64'(po.postoffice_csu_request),
                  64'(po.send_queue_postoffice_gl_index[grant]));
        end
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            rr = 0;
        end else if (acc) begin
            exp_q.push_back('{dst_reg: po.send_queue_postoffice_register[grant],
                              value:   dok,
                              gl:      po.send_queue_postoffice_gl_index[grant]});
            rr = (grant + 1) % NC;
        end
    endtask

    // Asynchronous reset asserted between clock edges with traffic still offered.
    task automatic async_reset();
        #3;
        po.send_queue_postoffice_valid = '1;
        po.loopback_postoffice_ready   = 1'b1;
        po.csu_postoffice_grant        = 1'b1;
        rst                            = 1'b1;
        #1;
        check("rst_ready", 64'(po.postoffice_send_queue_ready), 64'(0));
        check("rst_loopback_valid", 64'(po.postoffice_loopback_valid), 64'(0));
        check("rst_wb_valid", 64'(po.postoffice_writeback_arbiter_valid), 64'(0));
        check("rst_wb_count", 64'(wb_count), 64'(0));
        exp_q.delete();
        rr = 0;
        @(negedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the arbiter consumes the head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("wb_valid", 64'(po.postoffice_writeback_arbiter_valid),
                      64'(exp_q.size() != 0));
                check("wb_count", 64'(wb_count), 64'(exp_q.size()));
                if (po.writeback_arbiter_postoffice_acknowledge && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wb_register", 64'(po.postoffice_writeback_arbiter_register),
                          64'(e.dst_reg));
                    check("wb_value", 64'(po.postoffice_writeback_arbiter_value), 64'(e.value));
                    check("wb_gl_index", 64'(po.postoffice_writeback_arbiter_gl_index),
                          64'(e.gl));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        check("init_wb_count", 64'(wb_count), 64'(0));
        check("init_wb_valid", 64'(po.postoffice_writeback_arbiter_valid), 64'(0));
        check("init_ready", 64'(po.postoffice_send_queue_ready), 64'(0));
        check("init_loopback_valid", 64'(po.postoffice_loopback_valid), 64'(0));
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 7; p++) begin
            for (int n = 0; n < phases[p][5]; n++) begin
                cycle(phases[p][0], phases[p][1], phases[p][2], phases[p][3], phases[p][4]);
            end
            if (p == 1 || p == 5) async_reset();
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/postoffice_multichannel.md
Name: postoffice_multichannel

Overview:
Parametrised successor to the single-channel post office. Accepts send requests from NUM_CHANNELS send queues through a round-robin arbiter and validates each destination hart ID against a configurable [MIN_HARTID, MAX_HARTID] window. Valid messages are forwarded to the loopback interceptor under commit-safety-unit (CSU) grant. A WB_DEPTH-entry FIFO replaces the single writeback holding register, so send acceptance decouples from writeback-arbiter acknowledge latency.

Parameters:
NUM_CHANNELS, 2, number of send-queue input channels (>=1)
WB_DEPTH, 4, writeback FIFO entries (>=1, power of two not required)
MIN_HARTID, 0, lowest valid destination address (inclusive, unsigned)
MAX_HARTID, 64, highest valid destination address (inclusive, unsigned)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
send_queue_postoffice_valid  in  [NUM_CHANNELS]  per-channel request valid
postoffice_send_queue_ready  out  [NUM_CHANNELS]  per-channel accept (one-hot or zero)
send_queue_postoffice_data  in  send_queue_data_t[NUM_CHANNELS]  per-channel request
postoffice_writeback_arbiter_valid  out  1  FIFO head valid
writeback_arbiter_postoffice_acknowledge  in  1  head consumed
postoffice_writeback_arbiter_data  out  writeback_arbiter_data_t  FIFO head
postoffice_loopback_valid  out  1  message issued
loopback_postoffice_ready  in  1  loopback can take message
postoffice_loopback_data  out  interface_send_data_t  issued message
postoffice_csu_request  out  commit_safety_request_t  payload = granted channel's passthrough.gl_index (XCTCMSG_SARGANTANA builds only)
csu_postoffice_grant  in  1  CSU permits send
postoffice_wb_count  out  $clog2(WB_DEPTH+1)  current FIFO occupancy

Behaviour:
- Arbitration: rr_ptr in [0,NUM_CHANNELS-1]. Grant goes to the first valid channel at index >= rr_ptr, wrapping to 0. With no channel valid, there is no grant.
- rr_ptr advances to (granted+1) mod NUM_CHANNELS only on an accepted transfer. It holds while the granted channel is stalled, so there is no grant switching mid-stall.
- Destination check on the granted channel: dest_ok = (address >= MIN_HARTID) & (address <= MAX_HARTID), unsigned compare.
- wb_alloc_ok = (count < WB_DEPTH) | (ack & count != 0).
- accept = grant_exists & (dest_ok ? (loopback_ready & csu_grant) : 1) & wb_alloc_ok.
- ready[i] = accept & (grant == i). At most one channel accepts per cycle.
- postoffice_loopback_valid = accept & dest_ok. Loopback data.message = granted channel's message, combinational and zero-latency.
- On accept, enqueue {register, value = dest_ok ? 1 : 0, passthrough} at the tail. The entry is visible at the head no earlier than the next cycle.
- postoffice_writeback_arbiter_valid = (count != 0). Data is the head entry.
- ack with count != 0 pops the head. ack with count == 0 is ignored.
- Simultaneous enqueue and pop: permitted at any count, including full, where the count is unchanged. Head and tail pointers wrap modulo WB_DEPTH.
- Out-of-range requests still consume a FIFO slot; they never assert loopback_valid and never wait on csu_grant.
- rst (asynchronous) or flush (sampled on clk): count=0, head=tail=0, rr_ptr=0. Entry contents are don't-care.
- While rst is asserted, all ready bits, loopback_valid and writeback_valid read 0.
- A flush in the same cycle as accept wins: the entry is discarded, but the loopback transfer in that cycle still occurs. The flush owner is responsible for cancelling downstream.
- Reset values: wb_count=0, writeback_valid=0; ready/loopback_valid combinational and 0 with no valid input.

Test Plan:
- Reset, then ch0 valid with address 3, loopback_ready=1, csu_grant=1 -> ready[0]=1 and loopback_valid=1 the same cycle; next cycle writeback_valid=1, value=1, wb_count=1.
- NUM_CHANNELS=2, both valid every cycle, all downstream ready, ack held high -> grants alternate 0,1,0,1; each ready bit is high exactly every other cycle.
- Address 65 (MAX_HARTID=64) with csu_grant=0 -> accepted, loopback_valid=0, enqueued value=0. Address 64 -> dest_ok, but stalls until csu_grant=1.
- WB_DEPTH=4, ack held 0, 5 valid requests -> 4 accepted and wb_count=4; 5th has ready=0. Then ack=1 with a request present -> accept and pop in the same cycle, wb_count stays 4.
- Granted ch1 stalled on loopback_ready=0 while ch0 becomes valid -> grant stays on ch1 until accepted, then moves to ch0.
- FIFO holding 3 entries, flush pulse (and separately async rst mid-traffic) -> wb_count=0, writeback_valid=0 the next cycle, and rr_ptr restarts at ch0.
